id_ex_stage: RTL and testbench

- ID/EX pipeline register for the RV32 core. It sits directly upstream of ALU_Top and drives its pc_ex, reg_1_in, reg_2_in, imm_data_in, alu_mode_select and alu_op inputs.
- Captures decoded operands and controls from decode each cycle. Applies EX/MEM and MEM/WB operand forwarding.
- Detects load-use hazards and inserts bubbles. Honours downstream stall and branch-redirect flush.

---
 rtl/core_pkg.sv | 31 +++
 rtl/id_ex_stage_if.sv | 70 +++++++
 rtl/ex_fwd_unit.sv | 28 ++
 rtl/id_ex_stage.sv | 116 +++++++++++
 tb/tb_id_ex_stage.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared RV32 core definitions: datapath widths, ALU operand-mux encodings
// and the control bundle that an ID/EX bubble clears.
package core_pkg;

  localparam int XLEN       = 32;
  localparam int ALU_OP_W   = 5;
  localparam int ALU_MODE_W = 2;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [ALU_MODE_W-1:0] {
    MODE_RS1_RS2 = 2'd0,
    MODE_RS1_IMM = 2'd1,
    MODE_PC_IMM  = 2'd2,
    MODE_PC_RS2  = 2'd3
  } alu_mode_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ex_ctrl_t;

  localparam ex_ctrl_t NOP_CTRL = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0};

  // x0 is hardwired to zero, so a write to it never produces a dependency.
  function automatic logic rd_match(input logic [REG_ADDR_W-1:0] rd,
                                    input logic [REG_ADDR_W-1:0] rs);
    return (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-EX bundle: decode slot, pipeline controls, bypass sources and EX slot.
interface id_ex_stage_if import core_pkg::*; #(
  parameter int XLEN = 32
);

  logic                  stall_in;
  logic                  flush_in;
  logic                  id_valid_in;
  logic [XLEN-1:0]       pc_id_in;
  logic [XLEN-1:0]       rs1_data_in;
  logic [XLEN-1:0]       rs2_data_in;
  logic [XLEN-1:0]       imm_data_in;
  logic [REG_ADDR_W-1:0] rs1_addr_in;
  logic [REG_ADDR_W-1:0] rs2_addr_in;
  logic [REG_ADDR_W-1:0] rd_addr_in;
  logic [ALU_MODE_W-1:0] alu_mode_select_in;
  logic [ALU_OP_W-1:0]   alu_op_in;
  logic                  reg_write_in;
  logic                  mem_read_in;
  logic                  mem_write_in;
  logic [2:0]            funct3_in;

  logic                  exmem_reg_write_in;
  logic [REG_ADDR_W-1:0] exmem_rd_addr_in;
  logic [XLEN-1:0]       exmem_result_in;
  logic                  memwb_reg_write_in;
  logic [REG_ADDR_W-1:0] memwb_rd_addr_in;
  logic [XLEN-1:0]       memwb_result_in;

  logic                  ex_valid_out;
  logic [XLEN-1:0]       pc_ex_out;
  logic [XLEN-1:0]       imm_data_out;
  logic [XLEN-1:0]       reg_1_out;
  logic [XLEN-1:0]       reg_2_out;
  logic [REG_ADDR_W-1:0] rs1_addr_out;
  logic [REG_ADDR_W-1:0] rs2_addr_out;
  logic [REG_ADDR_W-1:0] rd_addr_out;
  logic [ALU_MODE_W-1:0] alu_mode_select_out;
  logic [ALU_OP_W-1:0]   alu_op_out;
  logic [2:0]            funct3_out;
  logic                  reg_write_out;
  logic                  mem_read_out;
  logic                  mem_write_out;
  logic                  load_use_stall_out;

  modport master (
    output stall_in, flush_in, id_valid_in, pc_id_in, rs1_data_in, rs2_data_in,
           imm_data_in, rs1_addr_in, rs2_addr_in, rd_addr_in, alu_mode_select_in,
           alu_op_in, reg_write_in, mem_read_in, mem_write_in, funct3_in,
           exmem_reg_write_in, exmem_rd_addr_in, exmem_result_in,
           memwb_reg_write_in, memwb_rd_addr_in, memwb_result_in,
    input  ex_valid_out, pc_ex_out, imm_data_out, reg_1_out, reg_2_out,
           rs1_addr_out, rs2_addr_out, rd_addr_out, alu_mode_select_out,
           alu_op_out, funct3_out, reg_write_out, mem_read_out, mem_write_out,
           load_use_stall_out
  );

  modport slave (
    input  stall_in, flush_in, id_valid_in, pc_id_in, rs1_data_in, rs2_data_in,
           imm_data_in, rs1_addr_in, rs2_addr_in, rd_addr_in, alu_mode_select_in,
           alu_op_in, reg_write_in, mem_read_in, mem_write_in, funct3_in,
           exmem_reg_write_in, exmem_rd_addr_in, exmem_result_in,
           memwb_reg_write_in, memwb_rd_addr_in, memwb_result_in,
    output ex_valid_out, pc_ex_out, imm_data_out, reg_1_out, reg_2_out,
           rs1_addr_out, rs2_addr_out, rd_addr_out, alu_mode_select_out,
           alu_op_out, funct3_out, reg_write_out, mem_read_out, mem_write_out,
           load_use_stall_out
  );

endinterface

// File: rtl/ex_fwd_unit.sv
// Operand bypass mux for one EX source register; EX/MEM beats MEM/WB, x0 never bypassed.
module ex_fwd_unit import core_pkg::*; #(
  parameter int XLEN       = 32,
  parameter bit ENABLE_FWD = 1'b1
) (
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [XLEN-1:0]       rs_data,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd_addr,
  input  logic [XLEN-1:0]       exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd_addr,
  input  logic [XLEN-1:0]       memwb_result,
  output logic [XLEN-1:0]       fwd_data
);

  always_comb begin
    fwd_data = rs_data;
    if (ENABLE_FWD) begin
      if (exmem_reg_write && rd_match(exmem_rd_addr, rs_addr)) begin
        fwd_data = exmem_result;
      end else if (memwb_reg_write && rd_match(memwb_rd_addr, rs_addr)) begin
        fwd_data = memwb_result;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decode, bypasses EX/MEM and MEM/WB results,
// inserts load-use bubbles and honours downstream stall and redirect flush.
module id_ex_stage import core_pkg::*; #(
  parameter int XLEN       = 32,
  parameter bit ENABLE_FWD = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  id_ex_stage_if.slave  bus
);

  typedef struct packed {
    logic                  valid;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
    alu_mode_e             alu_mode;
    logic [ALU_OP_W-1:0]   alu_op;
    logic [2:0]            funct3;
    ex_ctrl_t              ctrl;
  } ex_slot_t;

  ex_slot_t        slot_d, slot_q;
  logic [XLEN-1:0] reg_1_fwd, reg_2_fwd;
  logic            load_use;

  // A redirect kills the decode instruction anyway, so it cannot create a hazard.
  always_comb begin
    load_use = slot_q.valid && slot_q.ctrl.mem_read && bus.id_valid_in && !bus.flush_in &&
               (rd_match(slot_q.rd_addr, bus.rs1_addr_in) ||
                rd_match(slot_q.rd_addr, bus.rs2_addr_in));
  end

  ex_fwd_unit #(.XLEN(XLEN), .ENABLE_FWD(ENABLE_FWD)) u_fwd_rs1 (
    .rs_addr         (slot_q.rs1_addr),
    .rs_data         (slot_q.rs1_data),
    .exmem_reg_write (bus.exmem_reg_write_in),
    .exmem_rd_addr   (bus.exmem_rd_addr_in),
    .exmem_result    (bus.exmem_result_in),
    .memwb_reg_write (bus.memwb_reg_write_in),
    .memwb_rd_addr   (bus.memwb_rd_addr_in),
    .memwb_result    (bus.memwb_result_in),
    .fwd_data        (reg_1_fwd)
  );

  ex_fwd_unit #(.XLEN(XLEN), .ENABLE_FWD(ENABLE_FWD)) u_fwd_rs2 (
    .rs_addr         (slot_q.rs2_addr),
    .rs_data         (slot_q.rs2_data),
    .exmem_reg_write (bus.exmem_reg_write_in),
    .exmem_rd_addr   (bus.exmem_rd_addr_in),
    .exmem_result    (bus.exmem_result_in),
    .memwb_reg_write (bus.memwb_reg_write_in),
    .memwb_rd_addr   (bus.memwb_rd_addr_in),
    .memwb_result    (bus.memwb_result_in),
    .fwd_data        (reg_2_fwd)
  );

  always_comb begin
    slot_d = slot_q;
    if (bus.flush_in) begin
      slot_d      = '0;
      slot_d.ctrl = NOP_CTRL;
    end else if (bus.stall_in) begin
      // Re-latch bypassed operands so a writeback retiring mid-stall survives.
      slot_d.rs1_data = reg_1_fwd;
      slot_d.rs2_data = reg_2_fwd;
    end else if (load_use) begin
      slot_d      = '0;
      slot_d.ctrl = NOP_CTRL;
    end else begin
      slot_d.valid          = bus.id_valid_in;
      slot_d.pc             = bus.pc_id_in;
      slot_d.imm            = bus.imm_data_in;
      slot_d.rs1_data       = bus.rs1_data_in;
      slot_d.rs2_data       = bus.rs2_data_in;
      slot_d.rs1_addr       = bus.rs1_addr_in;
      slot_d.rs2_addr       = bus.rs2_addr_in;
      slot_d.rd_addr        = bus.rd_addr_in;
      slot_d.alu_mode       = alu_mode_e'(bus.alu_mode_select_in);
      slot_d.alu_op         = bus.alu_op_in;
      slot_d.funct3         = bus.funct3_in;
      slot_d.ctrl.reg_write = bus.reg_write_in && bus.id_valid_in;
      slot_d.ctrl.mem_read  = bus.mem_read_in  && bus.id_valid_in;
      slot_d.ctrl.mem_write = bus.mem_write_in && bus.id_valid_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign bus.ex_valid_out        = slot_q.valid;
  assign bus.pc_ex_out           = slot_q.pc;
  assign bus.imm_data_out        = slot_q.imm;
  assign bus.reg_1_out           = reg_1_fwd;
  assign bus.reg_2_out           = reg_2_fwd;
  assign bus.rs1_addr_out        = slot_q.rs1_addr;
  assign bus.rs2_addr_out        = slot_q.rs2_addr;
  assign bus.rd_addr_out         = slot_q.rd_addr;
  assign bus.alu_mode_select_out = slot_q.alu_mode;
  assign bus.alu_op_out          = slot_q.alu_op;
  assign bus.funct3_out          = slot_q.funct3;
  assign bus.reg_write_out       = slot_q.ctrl.reg_write && slot_q.valid;
  assign bus.mem_read_out        = slot_q.ctrl.mem_read  && slot_q.valid;
  assign bus.mem_write_out       = slot_q.ctrl.mem_write && slot_q.valid;
  assign bus.load_use_stall_out  = load_use;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: scoreboard of expected EX slots plus
// mid-cycle checks of bypassing and load-use detection.
module tb_id_ex_stage;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(32)) bus ();

  id_ex_stage #(.XLEN(32), .ENABLE_FWD(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic        valid;
    logic        rw;
    logic        mr;
    logic        mw;
    bit          chk_data;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic v, input logic rw, input logic mr,
                      input logic mw, input bit chk, input logic [31:0] r1,
                      input logic [31:0] r2, input logic [4:0] rd);
    exp_t e;
    e.tag = tag; e.valid = v; e.rw = rw; e.mr = mr; e.mw = mw;
    e.chk_data = chk; e.r1 = r1; e.r2 = r2; e.rd = rd;
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_valid"}, bus.ex_valid_out, e.valid);
      check({e.tag, "_rw"}, bus.reg_write_out, e.rw);
      check({e.tag, "_mr"}, bus.mem_read_out, e.mr);
      check({e.tag, "_mw"}, bus.mem_write_out, e.mw);
      if (e.chk_data) begin
        check({e.tag, "_reg1"}, bus.reg_1_out, e.r1);
        check({e.tag, "_reg2"}, bus.reg_2_out, e.r2);
        check({e.tag, "_rd"}, bus.rd_addr_out, e.rd);
      end
    end
  endtask

  task automatic decode(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [31:0] d1, input logic [4:0] rs2, input logic [31:0] d2,
                        input logic [4:0] rd, input logic rw, input logic mr, input logic mw);
    bus.id_valid_in        = v;
    bus.pc_id_in           = pc;
    bus.rs1_addr_in        = rs1;
    bus.rs1_data_in        = d1;
    bus.rs2_addr_in        = rs2;
    bus.rs2_data_in        = d2;
    bus.rd_addr_in         = rd;
    bus.imm_data_in        = pc ^ 32'h0000_0F00;
    bus.alu_mode_select_in = 2'd1;
    bus.alu_op_in          = 5'd3;
    bus.funct3_in          = 3'd2;
    bus.reg_write_in       = rw;
    bus.mem_read_in        = mr;
    bus.mem_write_in       = mw;
  endtask

  task automatic fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                     input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
    bus.exmem_reg_write_in = ew;
    bus.exmem_rd_addr_in   = erd;
    bus.exmem_result_in    = eres;
    bus.memwb_reg_write_in = mw;
    bus.memwb_rd_addr_in   = mrd;
    bus.memwb_result_in    = mres;
  endtask

  initial begin
    bus.stall_in = 1'b0;
    bus.flush_in = 1'b0;
    decode(1'b0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_valid", bus.ex_valid_out, 1'b0);
    check("reset_pc", bus.pc_ex_out, 32'h0);
    check("reset_reg1", bus.reg_1_out, 32'h0);
    check("reset_rd", bus.rd_addr_out, 5'd0);
    check("reset_rw", bus.reg_write_out, 1'b0);
    check("reset_load_use", bus.load_use_stall_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset pulsed between edges while EX holds a live instruction
    decode(1'b1, 32'h40, 5'd1, 32'h11, 5'd2, 32'h22, 5'd3, 1'b1, 1'b0, 1'b0);
    push("pre_rst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h11, 32'h22, 5'd3);
    step();
    check("pre_rst_pc", bus.pc_ex_out, 32'h40);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", bus.ex_valid_out, 1'b0);
    check("async_rst_pc", bus.pc_ex_out, 32'h0);
    check("async_rst_reg1", bus.reg_1_out, 32'h0);
    check("async_rst_rw", bus.reg_write_out, 1'b0);
    #1 rst_n = 1'b1;
    decode(1'b1, 32'h44, 5'd1, 32'h44, 5'd2, 32'h55, 5'd6, 1'b1, 1'b0, 1'b0);
    push("post_rst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h44, 32'h55, 5'd6);
    step();
    check("post_rst_pc", bus.pc_ex_out, 32'h44);

    // Plain capture of an add
    decode(1'b1, 32'h100, 5'd3, 32'h10, 5'd4, 32'h20, 5'd5, 1'b1, 1'b0, 1'b0);
    push("capture", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 32'h20, 5'd5);
    step();
    check("capture_pc", bus.pc_ex_out, 32'h100);
    check("capture_imm", bus.imm_data_out, 32'h100 ^ 32'h0000_0F00);
    check("capture_rs1_addr", bus.rs1_addr_out, 5'd3);
    check("capture_alu_op", bus.alu_op_out, 5'd3);

    // Invalid decode slot: controls are gated off
    decode(1'b0, 32'h104, 5'd3, 32'h10, 5'd4, 32'h20, 5'd5, 1'b1, 1'b1, 1'b1);
    push("invalid_slot", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();

    // Bypass priority on a held rs1=7 / rs2=8
    decode(1'b1, 32'h200, 5'd7, 32'h7777, 5'd8, 32'h8888, 5'd10, 1'b1, 1'b0, 1'b0);
    push("fwd_base", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h7777, 32'h8888, 5'd10);
    step();
    decode(1'b0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    fwd(1'b1, 5'd7, 32'hAAAA, 1'b1, 5'd7, 32'hBBBB);
    #1;
    check("fwd_exmem_wins", bus.reg_1_out, 32'hAAAA);
    check("fwd_rs2_untouched", bus.reg_2_out, 32'h8888);
    bus.exmem_reg_write_in = 1'b0;
    #1;
    check("fwd_memwb", bus.reg_1_out, 32'hBBBB);
    fwd(1'b1, 5'd0, 32'hAAAA, 1'b1, 5'd0, 32'hBBBB);
    #1;
    check("fwd_x0_raw", bus.reg_1_out, 32'h7777);
    fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'hCCCC);
    #1;
    check("fwd_memwb_rs2", bus.reg_2_out, 32'hCCCC);
    fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    push("fwd_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();

    // Load-use: lw rd=9 then add using rs2=9
    decode(1'b1, 32'h300, 5'd2, 32'h3000, 5'd0, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0);
    push("lw", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h3000, 32'h0, 5'd9);
    step();
    decode(1'b1, 32'h304, 5'd1, 32'h1, 5'd9, 32'h0, 5'd11, 1'b1, 1'b0, 1'b0);
    #1;
    check("lu_detect", bus.load_use_stall_out, 1'b1);
    bus.flush_in = 1'b1;
    #1;
    check("lu_flush_gated", bus.load_use_stall_out, 1'b0);
    bus.flush_in = 1'b0;
    #1;
    check("lu_detect_again", bus.load_use_stall_out, 1'b1);
    push("lu_bubble", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    check("lu_cleared", bus.load_use_stall_out, 1'b0);
    bus.rs2_data_in = 32'h99;
    push("lu_add", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1, 32'h99, 5'd11);
    step();

    // Stall with a MEM/WB write to the held rs1 during the second stall cycle
    decode(1'b1, 32'h400, 5'd6, 32'h600, 5'd2, 32'h222, 5'd12, 1'b1, 1'b0, 1'b0);
    push("stall_base", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h600, 32'h222, 5'd12);
    step();
    decode(1'b1, 32'h404, 5'd1, 32'h5555, 5'd2, 32'h6666, 5'd14, 1'b1, 1'b0, 1'b0);
    bus.stall_in = 1'b1;
    push("stall_c1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h600, 32'h222, 5'd12);
    step();
    check("stall_c1_pc", bus.pc_ex_out, 32'h400);
    fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h1234);
    #1;
    check("stall_wb_fwd", bus.reg_1_out, 32'h1234);
    push("stall_c2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1234, 32'h222, 5'd12);
    step();
    fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    push("stall_c3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1234, 32'h222, 5'd12);
    step();
    bus.stall_in = 1'b0;
    #1;
    check("stall_wb_kept", bus.reg_1_out, 32'h1234);
    push("stall_release", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h5555, 32'h6666, 5'd14);
    step();
    check("stall_release_pc", bus.pc_ex_out, 32'h404);

    // Stall together with load-use: EX holds, upstream told to hold
    decode(1'b1, 32'h500, 5'd3, 32'h3333, 5'd4, 32'h4444, 5'd13, 1'b1, 1'b1, 1'b0);
    push("slu_lw", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h3333, 32'h4444, 5'd13);
    step();
    decode(1'b1, 32'h504, 5'd13, 32'h0, 5'd4, 32'h4444, 5'd15, 1'b1, 1'b0, 1'b1);
    bus.stall_in = 1'b1;
    #1;
    check("slu_detect", bus.load_use_stall_out, 1'b1);
    push("slu_hold", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h3333, 32'h4444, 5'd13);
    step();
    check("slu_still_high", bus.load_use_stall_out, 1'b1);
    bus.stall_in = 1'b0;
    push("slu_bubble", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    bus.rs1_data_in = 32'hD00D;
    push("slu_store", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hD00D, 32'h4444, 5'd15);
    step();

    // Flush beats stall
    decode(1'b1, 32'h600, 5'd1, 32'h1, 5'd2, 32'h2, 5'd16, 1'b1, 1'b0, 1'b0);
    bus.flush_in = 1'b1;
    bus.stall_in = 1'b1;
    push("flush_stall", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    bus.flush_in = 1'b0;
    bus.stall_in = 1'b0;
    decode(1'b0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    push("tail_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
